random_arrow_gen: RTL

RANDOM_ARROW_GEN -- requirements
Module: random_arrow_gen

---
 rtl/random_arrow_gen_if.sv | 14 +
 rtl/random_arrow_gen.sv | 75 +++++++
 2 files changed

// File: rtl/random_arrow_gen_if.sv
// rtl/random_arrow_gen_if.sv - control and press-pattern signals of the arrow generator
interface random_arrow_gen_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic             enable;
  logic             step;
  logic [WIDTH-1:0] threshold;
  logic [LANES-1:0] press;
  logic             press_valid;

  modport master (output enable, output step, output threshold, input press, input press_valid);
  modport slave  (input enable, input step, input threshold, output press, output press_valid);
endinterface

// File: rtl/random_arrow_gen.sv
// rtl/random_arrow_gen.sv - per-lane LFSR arrow pattern generator with cooldown and simultaneity cap
module random_arrow_gen #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int GAP       = 2,
  parameter int MAX_SIMUL = 2
) (
  input logic               Clock,
  input logic               Reset,
  random_arrow_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] TAPS = (WIDTH == 8)  ? WIDTH'(32'h00B8) :
                                      (WIDTH == 12) ? WIDTH'(32'h0E08) :
                                                      WIDTH'(32'hB400);

  function automatic logic [WIDTH-1:0] seed(input int i);
    return WIDTH'(2 * i + 1);
  endfunction

  logic [WIDTH-1:0] lfsr_q [LANES];
  logic [WIDTH-1:0] lfsr_d [LANES];
  logic [3:0]       cd_q   [LANES];
  logic [3:0]       cd_d   [LANES];
  logic [LANES-1:0] press_q, press_d;
  logic             press_valid_q, press_valid_d;
  logic [3:0]       grant_cnt;

  always_comb begin
    lfsr_d        = lfsr_q;
    cd_d          = cd_q;
    press_d       = press_q;
    press_valid_d = 1'b0;
    grant_cnt     = 4'd0;
    if (bus.enable) begin
      for (int i = 0; i < LANES; i++) begin
        // an all-zero register would never leave zero, so it restarts from its seed
        lfsr_d[i] = (lfsr_q[i] == '0) ? seed(i)
                                      : {lfsr_q[i][WIDTH-2:0], ^(lfsr_q[i] & TAPS)};
      end
      if (bus.step) begin
        press_valid_d = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          if ((lfsr_q[i] < bus.threshold) && (cd_q[i] == 4'd0) &&
              (grant_cnt < 4'(MAX_SIMUL))) begin
            press_d[i] = 1'b1;
            cd_d[i]    = 4'(GAP);
            grant_cnt  = grant_cnt + 4'd1;
          end else begin
            press_d[i] = 1'b0;
            if (cd_q[i] != 4'd0) cd_d[i] = cd_q[i] - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LANES; i++) begin
        lfsr_q[i] <= seed(i);
        cd_q[i]   <= 4'd0;
      end
      press_q       <= '0;
      press_valid_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      cd_q          <= cd_d;
      press_q       <= press_d;
      press_valid_q <= press_valid_d;
    end
  end

  assign bus.press       = press_q;
  assign bus.press_valid = press_valid_q;
endmodule
